// File: rtl/pong_pkg.sv
// Shared constants and encodings for the pong field blocks.
package pong_pkg;

  localparam int WIDTH_DEF        = 16;
  localparam int BIT_OF_WIDTH_DEF = 4;

  // Field edge reported with a miss
  typedef enum logic [1:0] {
    SIDE_LEFT  = 2'b00,
    SIDE_RIGHT = 2'b01,
    SIDE_TOP   = 2'b10,
    SIDE_DOWN  = 2'b11
  } side_t;

  // Ball controller states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SERVE = 2'b01,
    ST_MOVE  = 2'b10,
    ST_MISS  = 2'b11
  } state_t;

endpackage

// File: rtl/step_timer.sv
// Free-running step counter: strobes step on the last count of each period.
// Holding en low freezes the count, so a step that falls on a frozen cycle
// fires on the first enabled cycle instead.
module step_timer #(
  parameter int STEP_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic en,
  output logic step
);

  localparam int CW = (STEP_CYCLES > 2) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(STEP_CYCLES - 1);

  logic [CW-1:0] count;

  assign step = en && (count == LAST);

  // Count up while enabled, wrapping to zero on the step cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en) begin
      count <= step ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/ball_mover.sv
// Ball owner for the four-paddle field: serves, steps, reflects on collide
// flags from find_cand and reports which edge the ball reached.
//
// state    | meaning
// ST_IDLE  | after reset, ball parked at centre, waiting for start
// ST_SERVE | one cycle: recentre ball, load serve direction, clear timer
// ST_MOVE  | ball steps one cell per timer strobe
// ST_MISS  | ball frozen on an edge, waiting for start
module ball_mover
  import pong_pkg::*;
#(
  parameter int WIDTH        = WIDTH_DEF,
  parameter int BIT_OF_WIDTH = BIT_OF_WIDTH_DEF,
  parameter int STEP_CYCLES  = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [1:0]                serve_dir,
  input  logic                      pause,
  input  logic [1:0]                collide,
  output logic [2*BIT_OF_WIDTH-1:0] pos,
  output logic                      moving,
  output logic                      miss,
  output logic [1:0]                miss_side
);

  localparam logic [BIT_OF_WIDTH-1:0] CENTRE = BIT_OF_WIDTH'(WIDTH / 2);
  localparam logic [BIT_OF_WIDTH-1:0] EDGE_HI = BIT_OF_WIDTH'(WIDTH - 1);

  state_t                  state;
  logic [BIT_OF_WIDTH-1:0] x, y;
  logic                    dx_neg, dy_neg;
  logic                    step;

  logic                    ndx_neg, ndy_neg;
  logic [BIT_OF_WIDTH-1:0] nx, ny;
  logic                    hit;
  side_t                   nside;

  assign pos = {x, y};

  step_timer #(.STEP_CYCLES(STEP_CYCLES)) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (state == ST_SERVE),
    .en    ((state == ST_MOVE) && !pause),
    .step  (step)
  );

  // Next position after reflection, and which edge (if any) it lands on;
  // the x edges are tested first so they win at corners
  always_comb begin
    ndx_neg = dx_neg ^ collide[0];
    ndy_neg = dy_neg ^ collide[1];
    nx      = ndx_neg ? x - 1'b1 : x + 1'b1;
    ny      = ndy_neg ? y - 1'b1 : y + 1'b1;
    hit     = 1'b1;
    nside   = SIDE_LEFT;
    if (nx == '0)          nside = SIDE_LEFT;
    else if (nx == EDGE_HI) nside = SIDE_RIGHT;
    else if (ny == '0)      nside = SIDE_TOP;
    else if (ny == EDGE_HI) nside = SIDE_DOWN;
    else                    hit   = 1'b0;
  end

  // Controller FSM with ball position, direction and registered flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      x         <= CENTRE;
      y         <= CENTRE;
      dx_neg    <= 1'b0;
      dy_neg    <= 1'b0;
      moving    <= 1'b0;
      miss      <= 1'b0;
      miss_side <= SIDE_LEFT;
    end else begin
      miss <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) state <= ST_SERVE;
        end
        ST_SERVE: begin
          x         <= CENTRE;
          y         <= CENTRE;
          dx_neg    <= serve_dir[1];
          dy_neg    <= serve_dir[0];
          miss_side <= SIDE_LEFT;
          moving    <= 1'b1;
          state     <= ST_MOVE;
        end
        ST_MOVE: begin
          if (step) begin
            dx_neg <= ndx_neg;
            dy_neg <= ndy_neg;
            x      <= nx;
            y      <= ny;
            if (hit) begin
              miss      <= 1'b1;
              miss_side <= nside;
              moving    <= 1'b0;
              state     <= ST_MISS;
            end
          end
        end
        ST_MISS: begin
          if (start) state <= ST_SERVE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
